// File: rtl/wb_ram_bank_arbiter.sv
// wb_ram_bank_arbiter: shares one sync-read single-port RAM bank between Wishbone ports A and B (WB_ARB_LOCK_EN adds cyc-based ownership with MAX_HOLD handover).
// Latency: accept to ack is one cycle; one macro access per cycle across both ports.
// Backpressure: a requester that is not granted sees stall; stall is forced high while rst_i is asserted.
module wb_ram_bank_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pA_cyc_i,
    input  logic              pA_stb_i,
    input  logic [3:0]        pA_we_i,
    input  logic [ADDR_W-1:0] pA_addr_i,
    input  logic [31:0]       pA_data_i,
    output logic [31:0]       pA_data_o,
    output logic              pA_ack_o,
    output logic              pA_stall_o,
    input  logic              pB_cyc_i,
    input  logic              pB_stb_i,
    input  logic [3:0]        pB_we_i,
    input  logic [ADDR_W-1:0] pB_addr_i,
    input  logic [31:0]       pB_data_i,
    output logic [31:0]       pB_data_o,
    output logic              pB_ack_o,
    output logic              pB_stall_o,
    output logic              ram_en_o,
    output logic [3:0]        ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_din_o,
    input  logic [31:0]       ram_dout_i
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..255");
    end

    logic req_a, req_b;
    logic gnt_a, gnt_b;
    logic rr_q, rr_d;               // 0 prefers A, 1 prefers B on contention
    logic pend_a_q, pend_b_q;
    logic rd_a_q, rd_b_q;
    logic [31:0] data_a_q, data_b_q;
    logic ack_a, ack_b;

`ifdef WB_ARB_LOCK_EN
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
    state_t state_q, state_d;
    logic [7:0] hold_q, hold_d;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
`endif

    assign req_a = pA_cyc_i & pA_stb_i;
    assign req_b = pB_cyc_i & pB_stb_i;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        rr_d  = rr_q;
`ifdef WB_ARB_LOCK_EN
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            OWN_A: begin
                gnt_a = req_a;
                gnt_b = !req_a && req_b;
                if (!pA_cyc_i) begin
                    state_d = IDLE;
                end else if (gnt_a && req_b) begin
                    // hold counts owner grants made while the other port waits
                    if (hold_q == HOLD_LAST) state_d = OWN_B;
                    else                     hold_d  = hold_q + 8'd1;
                end
            end
            OWN_B: begin
                gnt_b = req_b;
                gnt_a = !req_b && req_a;
                if (!pB_cyc_i) begin
                    state_d = IDLE;
                end else if (gnt_b && req_a) begin
                    if (hold_q == HOLD_LAST) state_d = OWN_A;
                    else                     hold_d  = hold_q + 8'd1;
                end
            end
            default: begin
                if (req_a && req_b) begin
                    gnt_a = !rr_q;
                    gnt_b = rr_q;
                    rr_d  = !rr_q;
                end else begin
                    gnt_a = req_a;
                    gnt_b = req_b;
                end
                if (gnt_a)      state_d = OWN_A;
                else if (gnt_b) state_d = OWN_B;
                else            state_d = IDLE;
            end
        endcase
        if (state_d != state_q) hold_d = 8'd0;
`else
        if (req_a && req_b) begin
            gnt_a = !rr_q;
            gnt_b = rr_q;
            rr_d  = !rr_q;
        end else begin
            gnt_a = req_a;
            gnt_b = req_b;
        end
`endif
        if (rst_i) begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end
    end

    assign ram_en_o   = gnt_a | gnt_b;
    assign ram_we_o   = gnt_a ? pA_we_i : (gnt_b ? pB_we_i : 4'b0000);
    assign ram_addr_o = gnt_b ? pB_addr_i : pA_addr_i;
    assign ram_din_o  = gnt_b ? pB_data_i : pA_data_i;

    assign pA_stall_o = rst_i | (req_a & !gnt_a);
    assign pB_stall_o = rst_i | (req_b & !gnt_b);

    // The macro access always completes; only the ack is dropped if cyc fell.
    assign ack_a    = pend_a_q & pA_cyc_i & !rst_i;
    assign ack_b    = pend_b_q & pB_cyc_i & !rst_i;
    assign pA_ack_o = ack_a;
    assign pB_ack_o = ack_b;
    assign pA_data_o = (ack_a && rd_a_q) ? ram_dout_i : data_a_q;
    assign pB_data_o = (ack_b && rd_b_q) ? ram_dout_i : data_b_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q     <= 1'b0;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            rd_a_q   <= 1'b0;
            rd_b_q   <= 1'b0;
            data_a_q <= 32'd0;
            data_b_q <= 32'd0;
`ifdef WB_ARB_LOCK_EN
            state_q  <= IDLE;
            hold_q   <= 8'd0;
`endif
        end else begin
            rr_q     <= rr_d;
            pend_a_q <= gnt_a;
            pend_b_q <= gnt_b;
            rd_a_q   <= gnt_a && (pA_we_i == 4'b0000);
            rd_b_q   <= gnt_b && (pB_we_i == 4'b0000);
            if (ack_a && rd_a_q) data_a_q <= ram_dout_i;
            if (ack_b && rd_b_q) data_b_q <= ram_dout_i;
`ifdef WB_ARB_LOCK_EN
            state_q  <= state_d;
            hold_q   <= hold_d;
`endif
        end
    end

endmodule

// File: doc/wb_ram_bank_arbiter.md
# wb_ram_bank_arbiter

Two-master Wishbone arbiter that shares one single-port DFFRAM macro (synchronous read, one access per cycle) between port A and port B. It sits between the two Wishbone slave ports of the dual-port RAM and each macro bank, one instance per bank. Same-bank conflicts are resolved by fair arbitration with per-port stall, so either port sees ordinary pipelined-Wishbone behaviour.

## Interface
Parameters:
- ADDR_W, 8, word-address width into the macro
- MAX_HOLD, 4, maximum consecutive grants to a locked owner while the other port waits (lock mode only); legal range 1–255

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- pA_cyc_i, pB_cyc_i  in  1  bus cycle
- pA_stb_i, pB_stb_i  in  1  strobe
- pA_we_i, pB_we_i  in  4  byte write enables; 0000 = read
- pA_addr_i, pB_addr_i  in  ADDR_W  word address
- pA_data_i, pB_data_i  in  32  write data
- pA_data_o, pB_data_o  out  32  read data
- pA_ack_o, pB_ack_o  out  1  acknowledge
- pA_stall_o, pB_stall_o  out  1  request not accepted this cycle
- ram_en_o  out  1  macro enable
- ram_we_o  out  4  macro byte write enables
- ram_addr_o  out  ADDR_W  macro address
- ram_din_o  out  32  macro write data
- ram_dout_i  in  32  macro read data, valid the cycle after ram_en_o

## Operation
- Request: reqX = pX_cyc_i & pX_stb_i. Accept: reqX & !pX_stall_o. At most one accept per cycle.
- Grant selection is combinational from the current state and the requests. The winning port's we/addr/data drive ram_*_o and ram_en_o=1. With no winner: ram_en_o=0, ram_we_o=0.
- stall: pX_stall_o = reqX & !grantX. Held at 1 during rst_i.
- FSM states: IDLE, OWN_A, OWN_B, plus a 1-bit round-robin pointer rr (prefers A after reset) and a hold counter.
  - IDLE: single requester wins. If both request, rr wins and rr flips. The winner's state is entered when its cyc stays high.
  - OWN_X: X wins whenever reqX. The other port wins when !reqX.
  - OWN_X → IDLE when pX_cyc_i falls.
  - OWN_X → OWN_Y when hold counter reaches MAX_HOLD while reqY. Counter resets on every state change.
- Completion: an accept in cycle T gives pX_ack_o=1 in T+1 (single-cycle pulse per accept).
  - Read ack: pX_data_o = ram_dout_i combinationally, and the value is captured into a per-port hold register.
  - Outside read acks: pX_data_o = hold register. Write acks leave it unchanged.
- Back-to-back accepts for one port give consecutive acks, in order.
- If pX_cyc_i is low in T+1, the macro access still completes but ack is suppressed.

## Timing
- Reset values: ack_o=0, data_o=0, ram_en_o=0, ram_we_o=0, state IDLE, rr=A, hold counter 0.
- rst_i asserted mid-access: pending ack is discarded next cycle and no macro write occurs in any cycle where rst_i=1.
- Latency: 1 cycle accept→ack. Throughput: 1 access/cycle total, shared by both ports.
- Simultaneous same-cycle requests in IDLE: exactly one accept. The loser is accepted in the next cycle if it is still requesting, unless the winner entered OWN with continuous stb (lock mode).
- Read of an address written in the preceding cycle by the other port returns the new data.

## Configuration
- WB_ARB_LOCK_EN defined: OWN_A/OWN_B states with cyc-based lock and MAX_HOLD handover, as above.
- WB_ARB_LOCK_EN undefined: no OWN states and no hold counter. Arbitration is pure per-cycle round-robin: on contention rr wins and flips every contended cycle. Single requesters always win.

## Test plan
- Reset, then A writes DEADBEEF to addr 0x00 with we=1111 → pA_stall_o=0, ram_en_o=1 same cycle, pA_ack_o pulse next cycle; A read of 0x00 → pA_data_o=DEADBEEF on ack and held afterwards.
- A writes 11111111 @0x04 and B writes 22222222 @0x08 in the same cycle → one port stalled one cycle, both acked; readback returns 11111111 / 22222222.
- Both ports read @0x04 / @0x08 simultaneously, single-cycle strobes → acks in consecutive cycles; A=11111111, B=22222222; first winner is A after reset and B on the next contention.
- Byte mask: write FFFFFFFF to 0x10, then 00000000 with we=0101 → read gives FF00FF00.
- Lock mode, MAX_HOLD=4: A streams reads with cyc held while B requests continuously → A gets 4 accepts, then B is accepted. Without WB_ARB_LOCK_EN the grants alternate every cycle.
- rst_i raised the cycle after an A write accept → no pA_ack_o, all outputs at reset values next cycle.
